uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter, the counterpart of the team's existing UART receiver; same 8N1 framing, same runtime baud configuration word.
- Accepts bytes through a small FIFO with valid/ready handshake and serialises them LSB-first with one start bit and one stop bit.
- Sits between the on-chip result/command logic and the board TX pin.

Parameters:
- UART_DATA_WIDTH, 8, data bits per frame.
- CONFIG_DATA_WIDTH, 32, width of baud configuration word.
- FIFO_DEPTH, 4, byte buffer entries; power of two, at least 2.

Ports:
- i_Clock  input  1  system clock; sole clock domain.
- i_Reset  input  1  synchronous, active-high reset.
- uart_config_data  input  CONFIG_DATA_WIDTH  clocks per bit (same meaning as receiver bit period).
- i_Tx_DV  input  1  byte valid; push strobe.
- i_Tx_Byte  input  UART_DATA_WIDTH  byte to send.
- o_Tx_Ready  output  1  FIFO not full; a push is accepted when i_Tx_DV && o_Tx_Ready.
- o_Tx_Serial  output  1  serial line, idle high, registered.
- o_Tx_Active  output  1  high while a frame is on the line (start through stop).
- o_Tx_Done  output  1  one-cycle pulse at end of each frame.

Behaviour:
- Single clock i_Clock; reset is synchronous and active-high on i_Reset.
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, FIFO empty (pointers/count 0), state IDLE, counters 0.
- Reset mid-frame: line high the cycle after reset is sampled; frame aborted; buffered bytes discarded; no o_Tx_Done.
- Bit period P = uart_config_data, latched into an internal register when a byte is popped. Values 0 or 1 are clamped to P=2. Config changes mid-frame have no effect until the next frame.
- FIFO:
  - o_Tx_Ready = (count != FIFO_DEPTH), from registered count.
  - A push while full is dropped silently.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - A full FIFO still reports not-ready in the pop cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, START, DATA, STOP and CLEANUP.
- IDLE: line high.
  - If FIFO count != 0: pop the head into the shift register, latch P, clear the counter, go to START.
  - The line drives 0 from the next cycle.
- START: line 0 for exactly P cycles; the counter runs 0..P-1, then goes to DATA with bit index 0.
- DATA: line = shift_reg[bit_index] for P cycles per bit, LSB first.
  - After bit UART_DATA_WIDTH-1, go to STOP.
  - The bit index counter is wide enough for UART_DATA_WIDTH.
- STOP: line 1 for P cycles. In the last STOP cycle, o_Tx_Done <= 1 (visible for one cycle), then go to CLEANUP.
- CLEANUP: line 1 for one cycle, then go to IDLE.
- o_Tx_Active is 1 in START, DATA and STOP; 0 in IDLE and CLEANUP.
- Frame length is 10*P cycles (start + 8 data + stop).
- Back-to-back frames: high line between consecutive stop and start bits is exactly 2 extra cycles (CLEANUP + IDLE).
- Latency: push at cycle 0 into an empty FIFO with an idle FSM. FIFO is non-empty at cycle 1, IDLE pops at cycle 1, and the start bit begins (line low) at cycle 2.
- Counter compare is equality on CONFIG_DATA_WIDTH-bit values; no overflow for any P ≤ 2^CONFIG_DATA_WIDTH-1.
- Unused/illegal state encodings return to IDLE with line high.

Test Plan:
- Reset then idle, 50 cycles: o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0 throughout.
- P=4, push 0xA5 at cycle 0:
  - Line 0 for cycles 2-5.
  - Data 1,0,1,0,0,1,0,1, each 4 cycles (cycles 6-37).
  - Line 1 for cycles 38-41.
  - o_Tx_Done=1 only at cycle 42.
  - o_Tx_Active=1 for cycles 2-41.
  - Loopback into the existing receiver configured for the same bit period recovers 0xA5.
- P=4, push 0x00, 0xFF, 0x3C, 0x81, 0x55 on consecutive cycles:
  - First 4 accepted plus a 5th once a pop frees space; o_Tx_Ready drops when count=4.
  - Frames appear in order, each 40 cycles, separated by exactly 2 high cycles.
  - A push while full is dropped.
- Change uart_config_data from 4 to 8 during the DATA state of a frame: current frame keeps P=4; next frame uses P=8 (80-cycle frame). Set config 0: frame uses P=2 (20 cycles).
- Assert i_Reset for 1 cycle during DATA with 2 bytes queued: line 1 next cycle, no o_Tx_Done, FIFO empty, o_Tx_Ready=1, no further frames.
- Full FIFO with simultaneous push and pop (IDLE popping while full): the push is rejected, count goes 4→3, and o_Tx_Ready=1 on the following cycle.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: bytes enter a small FIFO and leave as 8N1 frames, LSB first,
// with the bit period taken from a runtime configuration word at each pop.
module uart_tx #(
   parameter int UART_DATA_WIDTH   = 8,
   parameter int CONFIG_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                         i_Clock,
   input  logic                         i_Reset,
   input  logic [CONFIG_DATA_WIDTH-1:0] uart_config_data,
   // Handshake: a byte is accepted on any rising edge where i_Tx_DV && o_Tx_Ready;
   // o_Tx_Ready depends only on the registered fill count, never on i_Tx_DV.
   input  logic                         i_Tx_DV,
   input  logic [UART_DATA_WIDTH-1:0]   i_Tx_Byte,
   output logic                         o_Tx_Ready,
   output logic                         o_Tx_Serial,
   output logic                         o_Tx_Active,
   output logic                         o_Tx_Done,
   output logic [2:0]                   o_Tx_State
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int IDX_W = (UART_DATA_WIDTH > 1) ? $clog2(UART_DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_WIDTH - 1);
   localparam logic [CONFIG_DATA_WIDTH-1:0] P_MIN = CONFIG_DATA_WIDTH'(2);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } state_e;

   logic [UART_DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]             count_q, count_d;

   state_e                       state_q;
   logic [UART_DATA_WIDTH-1:0]   shift_q;
   logic [CONFIG_DATA_WIDTH-1:0] p_q;
   logic [CONFIG_DATA_WIDTH-1:0] cnt_q;
   logic [IDX_W-1:0]             idx_q;
   logic                         serial_q;
   logic                         active_q;
   logic                         done_q;

   logic                         push;
   logic                         pop;
   logic                         cnt_last;
   logic [IDX_W-1:0]             idx_nxt;
   logic [CONFIG_DATA_WIDTH-1:0] p_sel;

   assign push     = i_Tx_DV && (count_q != DEPTH_C);
   assign pop      = (state_q == IDLE) && (count_q != '0);
   assign cnt_last = (cnt_q == (p_q - CONFIG_DATA_WIDTH'(1)));
   assign idx_nxt  = idx_q + IDX_W'(1);
   // Periods below two would leave no room for the counter; clamp them.
   assign p_sel    = (uart_config_data < P_MIN) ? P_MIN : uart_config_data;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge i_Clock) begin
      if (push) fifo_q[wr_ptr_q] <= i_Tx_Byte;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Line value is registered one cycle ahead: each transition sets the level
   // that the next state must present from its first cycle.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         p_q      <= P_MIN;
         cnt_q    <= '0;
         idx_q    <= '0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               serial_q <= 1'b1;
               active_q <= 1'b0;
               if (pop) begin
                  shift_q  <= fifo_q[rd_ptr_q];
                  p_q      <= p_sel;
                  cnt_q    <= '0;
                  serial_q <= 1'b0;
                  active_q <= 1'b1;
                  state_q  <= START;
               end
            end
            START: begin
               if (cnt_last) begin
                  cnt_q    <= '0;
                  idx_q    <= '0;
                  serial_q <= shift_q[0];
                  state_q  <= DATA;
               end else begin
                  cnt_q <= cnt_q + CONFIG_DATA_WIDTH'(1);
               end
            end
            DATA: begin
               if (cnt_last) begin
                  cnt_q <= '0;
                  if (idx_q == IDX_LAST) begin
                     serial_q <= 1'b1;
                     state_q  <= STOP;
                  end else begin
                     idx_q    <= idx_nxt;
                     serial_q <= shift_q[idx_nxt];
                  end
               end else begin
                  cnt_q <= cnt_q + CONFIG_DATA_WIDTH'(1);
               end
            end
            STOP: begin
               serial_q <= 1'b1;
               if (cnt_last) begin
                  cnt_q    <= '0;
                  done_q   <= 1'b1;
                  active_q <= 1'b0;
                  state_q  <= CLEANUP;
               end else begin
                  cnt_q <= cnt_q + CONFIG_DATA_WIDTH'(1);
               end
            end
            CLEANUP: begin
               serial_q <= 1'b1;
               active_q <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               serial_q <= 1'b1;
               active_q <= 1'b0;
               cnt_q    <= '0;
               idx_q    <= '0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign o_Tx_Ready  = (count_q != DEPTH_C);
   assign o_Tx_Serial = serial_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_q;
   assign o_Tx_State  = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed pushes feed an expected queue; a line monitor
// decodes each frame, pops the queue and checks data, shape and done timing.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cfg = 32'd4;
   logic        dv = 1'b0;
   logic [7:0]  tx_byte = 8'h00;
   logic        ready, serial, active, done;
   logic [2:0]  dut_state;

   logic [7:0]  exp_q[$];
   int          exp_p_q[$];
   int          start_q[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        mon_abort = 1'b1;

   int          mstate = 0;
   int          mk, mp, mbad;
   logic [7:0]  mbyte, mexp;

   uart_tx #(
      .UART_DATA_WIDTH(8),
      .CONFIG_DATA_WIDTH(32),
      .FIFO_DEPTH(4)
   ) dut (
      .i_Clock(clk),
      .i_Reset(rst),
      .uart_config_data(cfg),
      .i_Tx_DV(dv),
      .i_Tx_Byte(tx_byte),
      .o_Tx_Ready(ready),
      .o_Tx_Serial(serial),
      .o_Tx_Active(active),
      .o_Tx_Done(done),
      .o_Tx_State(dut_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Driver tasks: called at a negedge, return at the following negedge.
   task automatic push(input logic [7:0] b, input int p, input logic exp_rdy);
      check("push_ready", int'(ready), int'(exp_rdy));
      dv = 1'b1;
      tx_byte = b;
      if (exp_rdy) begin
         exp_q.push_back(b);
         exp_p_q.push_back(p);
      end
      @(negedge clk);
      dv = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mon_abort = 1'b1;
      dv = 1'b0;
      exp_q.delete();
      exp_p_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check("rst_serial", int'(serial), 1);
      check("rst_active", int'(active), 0);
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(ready), 1);
      @(negedge clk);
      mon_abort = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc && (exp_q.size() != 0 || mstate != 0); i++)
         @(negedge clk);
      check("drain_timeout", int'(exp_q.size() != 0 || mstate != 0), 0);
      repeat (3) @(negedge clk);
   endtask

   // Monitor: behaves like a receiver locked to the expected bit period.
   task automatic mon_sample();
      int   seg;
      logic eb;
      seg = mk / mp;
      if (seg == 0)      eb = 1'b0;
      else if (seg == 9) eb = 1'b1;
      else               eb = mexp[seg-1];
      if (serial !== eb || active !== 1'b1 || done !== 1'b0) mbad++;
      if (seg >= 1 && seg <= 8 && (mk % mp) == mp / 2) mbyte[seg-1] = serial;
      mk++;
      if (mk == 10 * mp) mstate = 2;
   endtask

   always @(negedge clk) begin
      if (mon_abort) begin
         mstate = 0;
      end else begin
         case (mstate)
            0: begin
               if (done) check("stray_done", int'(done), 0);
               if (!serial) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_frame", 1, 0);
                     mstate = 4;
                  end else begin
                     mexp = exp_q.pop_front();
                     mp = exp_p_q.pop_front();
                     start_q.push_back(cyc);
                     mk = 0;
                     mbad = 0;
                     mbyte = 8'h00;
                     mstate = 1;
                     mon_sample();
                  end
               end
            end
            1: mon_sample();
            2: begin
               check("frame_shape_bad_cycles", mbad, 0);
               check("rx_byte", int'(mbyte), int'(mexp));
               check("done_active_serial", int'({done, active, serial}), 3'b101);
               mstate = 0;
            end
            default: if (serial) mstate = 0;
         endcase
      end
   end

   initial begin
      int c0;
      int b_ser, b_rdy, b_act, b_done;
      logic [7:0] burst [6];
      logic       burst_ok [6];
      burst = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h55, 8'h99};
      burst_ok = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset then idle
      repeat (4) @(negedge clk);
      rst = 1'b0;
      check("reset_serial", int'(serial), 1);
      check("reset_ready", int'(ready), 1);
      check("reset_active", int'(active), 0);
      check("reset_done", int'(done), 0);
      mon_abort = 1'b0;
      b_ser = 0; b_rdy = 0; b_act = 0; b_done = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (serial !== 1'b1) b_ser++;
         if (ready !== 1'b1)  b_rdy++;
         if (active !== 1'b0) b_act++;
         if (done !== 1'b0)   b_done++;
      end
      check("idle_serial_bad", b_ser, 0);
      check("idle_ready_bad", b_rdy, 0);
      check("idle_active_bad", b_act, 0);
      check("idle_done_bad", b_done, 0);

      // Single frame 0xA5 at P=4, start latency of two cycles
      start_q.delete();
      cfg = 32'd4;
      c0 = cyc;
      push(8'hA5, 4, 1'b1);
      wait_drain(200);
      check("start_latency", (start_q.size() > 0) ? start_q[0] - c0 : -1, 2);

      // Burst into the FIFO: five accepted, sixth dropped while full
      start_q.delete();
      c0 = cyc;
      for (int i = 0; i < 6; i++) push(burst[i], 4, burst_ok[i]);
      while (cyc < c0 + 43) @(negedge clk);
      push(8'h77, 4, 1'b0);
      check("ready_after_full_pop", int'(ready), 1);
      wait_drain(400);
      check("burst_frames", start_q.size(), 5);
      for (int i = 1; i < 5 && i < start_q.size(); i++)
         check("b2b_start_spacing", start_q[i] - start_q[i-1], 42);

      // Config change mid-frame, then clamped periods
      start_q.delete();
      cfg = 32'd4;
      push(8'h5A, 4, 1'b1);
      push(8'hC3, 8, 1'b1);
      repeat (15) @(negedge clk);
      cfg = 32'd8;
      wait_drain(400);
      check("cfg_b2b_spacing", (start_q.size() == 2) ? start_q[1] - start_q[0] : -1, 42);
      cfg = 32'd0;
      push(8'h96, 2, 1'b1);
      repeat (3) @(negedge clk);
      cfg = 32'd1;
      push(8'h3F, 2, 1'b1);
      wait_drain(200);

      // Reset during DATA with two bytes still queued
      cfg = 32'd4;
      push(8'h11, 4, 1'b1);
      push(8'h22, 4, 1'b1);
      push(8'h33, 4, 1'b1);
      repeat (12) @(negedge clk);
      check("pre_reset_in_frame", int'(active), 1);
      do_reset();
      b_ser = 0; b_done = 0; b_rdy = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (serial !== 1'b1) b_ser++;
         if (done !== 1'b0)   b_done++;
         if (ready !== 1'b1)  b_rdy++;
      end
      check("post_reset_low_cycles", b_ser, 0);
      check("post_reset_done_cycles", b_done, 0);
      check("post_reset_not_ready", b_rdy, 0);

      // Traffic resumes normally after the abort
      push(8'hE7, 4, 1'b1);
      wait_drain(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
